// File: rtl/edsac_tank_pkg.sv
// Shared types and sizing helpers for the serial tank interface blocks.
// Word and circulation defaults match one 36-digit, 32-word tank.
package edsac_tank_pkg;

    localparam int WORD_W_DEFAULT = 36;
    localparam int WORDS_DEFAULT  = 32;

    typedef enum logic [2:0] {
        UNSYNC,
        IDLE,
        SEEK,
        SHIFT,
        HOLD
    } state_t;

    // Bits needed to count 0..digits inclusive.
    function automatic int digit_cnt_w(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/tank_timing_tracker.sv
// Tracks which minor cycle is circulating; optional d0/mc0 spacing checker (TANK_READER_SYNC_CHECK_EN).
// Latency: cur_minor/synced/timing_fault are combinational from d0/mc0 and the registered count.
// Backpressure: none, follows the digit-pulse timing unconditionally.
module tank_timing_tracker
    import edsac_tank_pkg::*;
#(
`ifdef TANK_READER_SYNC_CHECK_EN
    parameter int WORD_W = WORD_W_DEFAULT,
`endif
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d0,
    input  logic              mc0,
    output logic [ADDR_W-1:0] cur_minor,
    output logic              synced,
    output logic              timing_fault
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] next_minor;

    always_comb begin
        next_minor = cnt_q;
        if (d0) begin
            next_minor = (cnt_q == ADDR_W'(WORDS - 1)) ? '0 : cnt_q + ADDR_W'(1);
        end
        // mc0 realigns the count regardless of where it had drifted to.
        cur_minor = (mc0 && d0) ? '0 : next_minor;
        cnt_d     = cur_minor;
    end

    assign synced = mc0 & d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef TANK_READER_SYNC_CHECK_EN
    localparam int DIG_W = $clog2(WORD_W);

    logic [DIG_W-1:0] dig_q;
    logic [DIG_W-1:0] dig_d;
    logic             armed_q;
    logic             armed_d;
    logic             fault;

    // dig_q is the digit index expected this cycle; d0 must land exactly on index 0.
    always_comb begin
        dig_d   = (dig_q == DIG_W'(WORD_W - 1)) ? '0 : dig_q + DIG_W'(1);
        armed_d = armed_q;
        fault   = 1'b0;
        if (d0) begin
            fault   = armed_q && (dig_q != '0);
            dig_d   = DIG_W'(1);
            armed_d = 1'b1;
        end else if (armed_q && (dig_q == '0)) begin
            fault   = 1'b1;
            armed_d = 1'b0;
        end
        if (mc0 && !d0) begin
            fault = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            dig_q   <= dig_d;
            armed_q <= armed_d;
        end
    end

    assign timing_fault = fault;
`else
    assign timing_fault = 1'b0;
`endif

endmodule

// File: rtl/tank_word_reader.sv
// Captures one requested 36-digit word from a circulating tank and returns it in parallel (TANK_READER_SYNC_CHECK_EN adds sync_err).
// Latency: rsp_valid rises 1 cycle after the last digit of the target word; worst case WORDS*WORD_W+WORD_W+1.
// Backpressure: one request in flight; rsp held stable until rsp_ready, req_ready low until then.
module tank_word_reader
    import edsac_tank_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int WORDS  = WORDS_DEFAULT,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d0,
    input  logic              mc0,
    input  logic              tank_out,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_word,
    input  logic              rsp_ready,
    output logic              sync_err
);

    localparam int CNT_W = digit_cnt_w(WORD_W);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] shifted;
    logic [ADDR_W-1:0] addr_mod;
    logic [ADDR_W-1:0] cur_minor;
    logic              synced;
    logic              timing_fault;

    tank_timing_tracker #(
`ifdef TANK_READER_SYNC_CHECK_EN
        .WORD_W (WORD_W),
`endif
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .d0           (d0),
        .mc0          (mc0),
        .cur_minor    (cur_minor),
        .synced       (synced),
        .timing_fault (timing_fault)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        dcnt_d   = dcnt_q;
        shreg_d  = shreg_q;
        word_d   = word_q;
        // Digits arrive LSB first, so after WORD_W right shifts digit 0 sits at bit 0.
        shifted  = {tank_out, shreg_q[WORD_W-1:1]};
        addr_mod = ADDR_W'(32'(req_addr) % WORDS);

        unique case (state_q)
            UNSYNC: begin
                if (synced) state_d = IDLE;
            end
            IDLE: begin
                if (req_valid) begin
                    addr_d  = addr_mod;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (d0 && (cur_minor == addr_q)) begin
                    shreg_d = shifted;
                    dcnt_d  = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A d0 here means the word was shorter than WORD_W digits: drop it.
                if (d0) begin
                    state_d = UNSYNC;
                end else begin
                    shreg_d = shifted;
                    dcnt_d  = dcnt_q + CNT_W'(1);
                    if (dcnt_q == CNT_W'(WORD_W - 1)) begin
                        word_d  = shifted;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = UNSYNC;
        endcase

        if (timing_fault) state_d = UNSYNC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSYNC;
            addr_q  <= '0;
            dcnt_q  <= '0;
            shreg_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dcnt_q  <= dcnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == HOLD);
    assign rsp_word  = word_q;

`ifdef TANK_READER_SYNC_CHECK_EN
    logic sync_err_q;
    logic sync_err_d;

    assign sync_err_d = sync_err_q | timing_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_tank_word_reader.sv
// Directed bench for tank_word_reader: a bench-side tank model drives d0/mc0/tank_out,
// and each step compares DUT outputs against hand-computed values.
module tb_tank_word_reader;

    localparam int WORD_W = 36;
    localparam int WORDS  = 32;

`ifdef TANK_READER_SYNC_CHECK_EN
    localparam logic EXP_SYNC_ERR = 1'b1;
`else
    localparam logic EXP_SYNC_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d0;
    logic        mc0;
    logic        tank_out;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [35:0] rsp_word;
    logic        rsp_ready;
    logic        sync_err;

    logic [35:0] mem [WORDS];
    int          minor;
    int          dig;
    bit          inject_d0;
    int          checks;
    int          errors;

    tank_word_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d0        (d0),
        .mc0       (mc0),
        .tank_out  (tank_out),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_word  (rsp_word),
        .rsp_ready (rsp_ready),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one digit time; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (inject_d0 || dig == WORD_W - 1) begin
            dig       = 0;
            minor     = (minor + 1) % WORDS;
            inject_d0 = 1'b0;
        end else begin
            dig++;
        end
        d0       = (dig == 0);
        mc0      = d0 && (minor == 0);
        tank_out = mem[minor][dig];
    endtask

    task automatic wait_pos(input string tag, input int m, input int d);
        int n = 0;
        while (!(minor == m && dig == d) && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_reach"}, (minor == m && dig == d), 1);
    endtask

    task automatic request(input string tag, input int addr);
        chk({tag, "_rdy"}, req_ready, 1);
        req_valid = 1'b1;
        req_addr  = 5'(addr);
        tick();
        req_valid = 1'b0;
        chk({tag, "_busy"}, req_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input int exp_minor, input int exp_ticks,
                            input logic [35:0] exp_word);
        int n = 0;
        while (!rsp_valid && n < 2600) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_pos"}, minor * WORD_W + dig, exp_minor * WORD_W);
        if (exp_ticks >= 0) chk({tag, "_lat"}, n, exp_ticks);
        chk({tag, "_word"}, rsp_word, exp_word);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        chk({tag, "_rdy_in_hold"}, req_ready, 0);
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, rsp_valid, 0);
        chk({tag, "_rdy_back"}, req_ready, 1);
    endtask

    initial begin
        int  n;
        bit  bad_a;
        bit  bad_b;

        checks    = 0;
        errors    = 0;
        for (int i = 0; i < WORDS; i++) mem[i] = 36'h5_0000_0000 + 36'(i * 3 + 1);
        mem[0]    = 36'hA_AAAA_AAAA;
        mem[3]    = 36'h1_2345_6789;
        mem[5]    = 36'h8_0000_0001;
        mem[7]    = 36'hC_0FFE_E123;
        mem[31]   = 36'hF_0F0F_0F0F;
        minor     = 29;
        dig       = WORD_W - 1;
        inject_d0 = 1'b0;
        rst_n     = 1'b0;
        d0        = 1'b0;
        mc0       = 1'b0;
        tank_out  = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;

        // Reset values
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_word", rsp_word, 0);
        chk("rst_sync_err", sync_err, 0);
        tick();
        rst_n = 1'b1;

        // Request held before the first mc0: not accepted until sync
        req_valid = 1'b1;
        req_addr  = 5'd0;
        bad_a = req_ready;
        n = 0;
        while (!mc0 && n < 200) begin
            tick();
            n++;
            if (req_ready) bad_a = 1'b1;
        end
        chk("presync_mc0_seen", mc0, 1);
        chk("presync_no_ready", bad_a, 0);
        tick();
        chk("sync_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        wait_rsp("w0", 1, 1186, 36'hA_AAAA_AAAA);
        consume("w0");

        // Request in the cycle before word 5's d0 catches it this circulation
        wait_pos("w5", 4, 35);
        request("w5", 5);
        wait_rsp("w5", 6, 36, 36'h8_0000_0001);
        consume("w5");

        // Word 31 with 100 cycles of consumer backpressure
        wait_pos("w31", 25, 0);
        request("w31", 31);
        wait_rsp("w31", 0, -1, 36'hF_0F0F_0F0F);
        bad_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_word !== 36'hF_0F0F_0F0F || req_ready !== 1'b0)
                bad_a = 1'b1;
        end
        chk("w31_hold_stable", bad_a, 0);
        consume("w31");

        // Accepted mid-word: waits a full circulation
        wait_pos("w3", 3, 10);
        request("w3", 3);
        wait_rsp("w3", 4, 1177, 36'h1_2345_6789);
        consume("w3");

        // Early d0 in SHIFT aborts the capture
        wait_pos("flt", 9, 0);
        request("flt", 10);
        wait_pos("flt_mid", 10, 19);
        inject_d0 = 1'b1;
        tick();
        chk("flt_no_valid", rsp_valid, 0);
        tick();
        chk("flt_unsync_ready", req_ready, 0);
        chk("flt_sync_err", sync_err, EXP_SYNC_ERR);
        bad_a = 1'b0;
        bad_b = 1'b0;
        n = 0;
        while (!mc0 && n < 1300) begin
            tick();
            n++;
            if (rsp_valid) bad_a = 1'b1;
            if (req_ready) bad_b = 1'b1;
        end
        chk("flt_mc0_seen", mc0, 1);
        chk("flt_no_rsp", bad_a, 0);
        chk("flt_stay_unsync", bad_b, 0);
        tick();
        chk("flt_resync_ready", req_ready, 1);
        chk("flt_sync_err_sticky", sync_err, EXP_SYNC_ERR);

        // Reset at digit 17 of a capture, then a fresh read
        request("rst7", 7);
        wait_pos("rst7", 7, 17);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_word", rsp_word, 0);
        chk("mid_rst_sync_err", sync_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bad_a = 1'b0;
        n = 0;
        while (!mc0 && n < 1300) begin
            tick();
            n++;
            if (rsp_valid || req_ready) bad_a = 1'b1;
        end
        chk("post_rst_quiet", bad_a, 0);
        tick();
        request("w7", 7);
        wait_rsp("w7", 8, 286, 36'hC_0FFE_E123);
        consume("w7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
